mem_burst_ctrl: RTL
===================

# mem_burst_ctrl

Burst initiator for the 16x8 single-port RAM (registered read address, combinational read data, 1-cycle read latency). It accepts a read or write burst command over a valid/ready handshake and drives the RAM's data/addr/we pins. Write data arrives from a valid/ready stream, and read data returns on a valid/ready stream with backpressure. It sits between a user-side command source and the RAM instance, making that RAM usable by streaming logic.

## Interface
- DW, 8, data width; matches RAM word.
- AW, 4, address width; RAM depth 2^AW.

- clk  in  1  rising-edge clock, shared with RAM.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept command.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  AW  burst start address.
- cmd_len  in  AW  burst length minus one (0 → 1 word, 15 → 16 words).
- wr_data  in  DW  write beat data.
- wr_valid  in  1  write beat present.
- wr_ready  out  1  controller takes write beat.
- rd_data  out  DW  read beat data.
- rd_valid  out  1  read beat present.
- rd_ready  in  1  consumer takes read beat.
- done  out  1  one-cycle pulse after last beat of any burst.
- mem_data  out  DW  to RAM data.
- mem_addr  out  AW  to RAM addr.
- mem_we  out  1  to RAM we.
- mem_q  in  DW  from RAM q.

## Operation
- States: IDLE, WRITE, READ. Registers: state, cur_addr (AW), remaining (AW, beats left minus one), done.
- Handshake rule: a transfer happens on a rising edge where valid and ready are both 1. Valid must not depend on ready.
- IDLE:
  - Outputs: cmd_ready=1, mem_addr=cmd_addr, mem_we=0.
  - On cmd handshake: cur_addr←cmd_addr, remaining←cmd_len, then state←WRITE if cmd_write, else READ.
  - The RAM latches cmd_addr on the same edge, so read data is valid in the first READ cycle.
- WRITE:
  - Outputs: wr_ready=1, mem_addr=cur_addr, mem_data=wr_data, mem_we=wr_valid.
  - On each beat: cur_addr←cur_addr+1 (mod 2^AW), remaining←remaining−1.
  - On the beat with remaining==0: state←IDLE, done←1.
- READ:
  - Outputs: rd_valid=1, rd_data=mem_q, mem_we=0.
  - mem_addr = cur_addr+1 when rd_ready and remaining≠0; otherwise mem_addr=cur_addr. Holding the address keeps rd_data stable during stalls.
  - On each beat: cur_addr++, remaining−−.
  - On the beat with remaining==0: state←IDLE, done←1.
- Address arithmetic wraps modulo 2^AW; a burst may cross address 15→0. A 16-word burst touches every address exactly once.
- No new command is accepted until the controller is back in IDLE.
- Outputs that are idle in the current state:
  - wr_ready=0 outside WRITE.
  - rd_valid=0 outside READ.
  - rd_data = mem_q in all states (ignore it when rd_valid=0).
  - mem_data = wr_data in all states.

## Timing
- Reset values: state=IDLE, cmd_ready=1, wr_ready=0, rd_valid=0, done=0, mem_we=0, cur_addr=0, remaining=0.
- mem_we is forced to 0 combinationally while rst=1. A reset asserted mid-burst never issues a write on that edge.
- Reset mid-burst: the next cycle is IDLE with no done pulse. The remaining beats are abandoned; RAM contents already written are kept.
- Write throughput: 1 beat/cycle; the RAM is updated on the handshake edge.
- Read latency: cmd handshake at edge N → first rd_valid in cycle N+1. Throughput is 1 beat/cycle with rd_ready held high.
- done rises on the edge of the last beat, lasts 1 cycle, and coincides with cmd_ready=1. A new command may be accepted in that same cycle.
- Back-to-back: a write burst followed by a read of the same address returns the newly written data. The RAM writes and latches the address on the same edge, and the read path sees the updated array.
- Combinational paths:
  - rd_ready → mem_addr.
  - cmd_addr → mem_addr.
  - wr_valid → mem_we.
  - wr_data → mem_data.
  - mem_q → rd_data.

## Test plan
- Reset: hold rst 2 cycles with wr_valid=1 → mem_we=0 throughout, cmd_ready=1, rd_valid=0, done=0.
- Write 4 words at 0x3 (cmd_len=3, data 0xA0..0xA3, wr_valid constant), then read 4 at 0x3 → rd_data 0xA0,0xA1,0xA2,0xA3 on 4 consecutive cycles; first beat 1 cycle after accept; done once per burst.
- Wrap: write 3 words at 0xE (0x11,0x22,0x33) → RAM[0xE]=0x11, RAM[0xF]=0x22, RAM[0x0]=0x33. Then read cmd_len=15 at 0x0 → 16 beats, first 0x33, wrapping through 0xF.
- Read backpressure: read 3 words at 0x3 with rd_ready low for 3 cycles at beat 2 → rd_data stays 0xA1 and rd_valid stays high while stalled; the sequence completes 0xA0,0xA1,0xA2 without loss or duplication.
- Write gaps: wr_valid toggles 1,0,0,1 for a 2-beat write → exactly 2 RAM writes at consecutive addresses; done after the second beat.
- Reset mid-read after beat 1 of 4 → IDLE next cycle, no done, rd_valid=0; a following command is accepted normally.

Source files
------------

// File: rtl/mem_burst_ctrl.sv
// Burst initiator for a 16x8 single-port RAM (registered read address, combinational q).
// Accepts read/write burst commands and streams beats over valid/ready.
module mem_burst_ctrl #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_write_i,
  input  logic [AW-1:0] cmd_addr_i,
  input  logic [AW-1:0] cmd_len_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          wr_valid_i,
  output logic          wr_ready_o,
  output logic [DW-1:0] rd_data_o,
  output logic          rd_valid_o,
  input  logic          rd_ready_i,
  output logic          done_o,
  output logic [DW-1:0] mem_data_o,
  output logic [AW-1:0] mem_addr_o,
  output logic          mem_we_o,
  input  logic [DW-1:0] mem_q_i
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] rem_q, rem_d;
  logic          done_q, done_d;
  logic [AW-1:0] addr_inc;

  assign addr_inc   = AW'(addr_q + 1'b1);
  assign rd_data_o  = mem_q_i;
  assign mem_data_o = wr_data_i;
  assign done_o     = done_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

  // Next-state and RAM-side drive; the RAM address is steered one beat ahead in READ.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    done_d      = 1'b0;
    cmd_ready_o = 1'b0;
    wr_ready_o  = 1'b0;
    rd_valid_o  = 1'b0;
    mem_addr_o  = addr_q;
    mem_we_o    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        mem_addr_o  = cmd_addr_i;
        if (cmd_valid_i) begin
          addr_d  = cmd_addr_i;
          rem_d   = cmd_len_i;
          state_d = cmd_write_i ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        wr_ready_o = 1'b1;
        mem_we_o   = wr_valid_i;
        if (wr_valid_i) begin
          addr_d = addr_inc;
          rem_d  = AW'(rem_q - 1'b1);
          if (rem_q == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      S_READ: begin
        rd_valid_o = 1'b1;
        if (rd_ready_i) begin
          // Holding the address while stalled keeps rd_data stable.
          mem_addr_o = (rem_q != '0) ? addr_inc : addr_q;
          addr_d     = addr_inc;
          rem_d      = AW'(rem_q - 1'b1);
          if (rem_q == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (rst_i) mem_we_o = 1'b0;
  end

endmodule
